l_inv_convertion: RTL and testbench
===================================

L_INV_CONVERTION -- requirements
Module: L_inv_convertion

Interface
REQ-001 SHALL have no parameters; the round count (16) and field polynomial are fixed.
REQ-002 SHALL have one clock and a synchronous, active-high reset. All state SHALL change only on the rising edge of clk. reset SHALL be sampled on that edge.
REQ-003 clk  input  1  clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  1 = start the inverse L transform; it SHALL be held high until finish_convertion is seen.
REQ-006 input_word  input  128  block to transform; byte 15 = [127:120], byte 0 = [7:0].
REQ-007 output_word  output  128  registered result L^-1(input_word), with the same byte order.
REQ-008 finish_convertion  output  1  1 = output_word is valid and stays stable while enable stays high.

Function
REQ-009 SHALL use a 16-byte register file r[15:0] (r[15] = MSB byte), a 2-bit state (IDLE, RUN, DONE) and a 4-bit round counter.
REQ-010 SHALL do all byte multiplication in GF(2^8) with the polynomial x^8+x^7+x^6+x+1 (0x1C3). The existing constant-multiplier table modules SHALL be used for this.
REQ-011 IDLE: finish_convertion <= 0 and counter <= 0. When enable = 1, r[i] <= input_word byte i for all i, and the state goes to RUN. When enable = 0, the state stays IDLE.
REQ-012 RUN, each cycle (one inverse round R^-1):
- r[i] <= r[i-1] for i = 15..1.
- r[0] <= r[15] ^ 148·r[14] ^ 32·r[13] ^ 133·r[12] ^ 16·r[11] ^ 194·r[10] ^ 192·r[9] ^ r[8] ^ 251·r[7] ^ r[6] ^ 192·r[5] ^ 194·r[4] ^ 16·r[3] ^ 133·r[2] ^ 32·r[1] ^ 148·r[0].
REQ-013 RUN SHALL run exactly 16 rounds. On the round where counter = 15, the state goes to DONE. Otherwise counter increments by 1.
REQ-014 DONE, every cycle: output_word <= {r[15],...,r[0]} and finish_convertion <= 1. If enable = 0 on that edge, the state goes to IDLE and finish_convertion <= 0; output_word keeps the loaded value.
REQ-015 Latency: if enable is sampled high in IDLE at edge E0, rounds occur at edges E1..E16, and finish_convertion and output_word become valid after edge E17.
REQ-016 enable and input_word SHALL be ignored during RUN. A deassert of enable during RUN SHALL NOT abort the operation.
REQ-017 While enable stays high in DONE, the block SHALL remain in DONE and SHALL NOT restart. A new operation requires enable low for at least one edge and then high in IDLE.
REQ-018 Inverse property: for any x, L_inv_convertion(L(x)) = x, where L is the team's forward L transform with the same byte order.
REQ-019 r[] SHALL have no reset requirement. Its contents are don't-care outside RUN and DONE.

Reset
REQ-020 When reset = 1 at an edge, the next values SHALL be: state = IDLE, counter = 0, output_word = 0, finish_convertion = 0. reset SHALL take priority over enable.
REQ-021 reset asserted during RUN or DONE SHALL abort the operation with no partial result visible. The first operation after reset is released SHALL start only from IDLE with enable = 1.

Verification
REQ-022 Vector: input_word = d456584dd0e3e84cc3166e4b7fa2890d with enable held -> finish_convertion = 1 exactly 17 edges after the load edge, and output_word = 64a59400000000000000000000000000.
REQ-023 Zero: input_word = 0 -> output_word = 0 and finish_convertion = 1 at the same latency as REQ-022.
REQ-024 Round trip: 1000 random x are passed through the forward L block and then this block -> the output equals x for every x.
REQ-025 Handshake: enable stays high for 5 edges after finish_convertion -> the output stays stable and no restart occurs. enable then drops -> finish_convertion = 0 after the next edge. enable is raised again with a new word -> a new result arrives after 17 edges.
REQ-026 Mid-run events: enable drops at round 8 -> the operation still completes. reset is asserted at round 8 of another run -> output_word = 0, finish_convertion = 0, the state is IDLE, and a following run gives the correct result.
REQ-027 input_word changes during RUN -> the result reflects only the word sampled at the load edge.

Source files
------------

// File: rtl/l_inv_convertion.sv
// Inverse L transform of the Kuznyechik cipher: sixteen inverse rounds R^-1 over a
// 16-byte shift register, with GF(2^8) arithmetic modulo x^8+x^7+x^6+x+1.

module l_inv_gf_mul_const #(
    parameter logic [7:0] K = 8'h01
) (
    input  logic [7:0] a_i,
    output logic [7:0] p_o
);
    logic [7:0] acc;
    logic [7:0] t;

    // Shift-and-add against a fixed constant; reduces to an XOR network.
    always_comb begin
        acc = 8'h00;
        t   = a_i;
        for (int b = 0; b < 8; b++) begin
            if (K[b]) begin
                acc = acc ^ t;
            end
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'hC3 : 8'h00);
        end
        p_o = acc;
    end
endmodule

module l_inv_convertion (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [127:0] input_word,
    output logic [127:0] output_word,
    output logic         finish_convertion,
    output logic [1:0]   state_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Feedback coefficient applied to r[i]; r[15] enters with weight 1.
    localparam logic [7:0] COEF [16] = '{
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0][7:0]  r_q, r_d;
    logic [127:0]      out_q, out_d;
    logic              fin_q, fin_d;
    logic [15:0][7:0]  prod;
    logic [7:0]        fb;

    for (genvar i = 0; i < 16; i++) begin : g_mul
        l_inv_gf_mul_const #(.K(COEF[i])) u_mul (
            .a_i (r_q[i]),
            .p_o (prod[i])
        );
    end

    always_comb begin
        fb = 8'h00;
        for (int i = 0; i < 16; i++) begin
            fb = fb ^ prod[i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        out_d   = out_q;
        fin_d   = fin_q;
        case (state_q)
            IDLE: begin
                fin_d = 1'b0;
                cnt_d = 4'd0;
                if (enable) begin
                    r_d     = input_word;
                    state_d = RUN;
                end
            end
            RUN: begin
                r_d = {r_q[14:0], fb};
                if (cnt_q == 4'd15) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                out_d = r_q;
                fin_d = 1'b1;
                // Result stays loaded after the handshake closes; only the flag drops.
                if (!enable) begin
                    state_d = IDLE;
                    fin_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                fin_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            out_q   <= 128'd0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            fin_q   <= fin_d;
        end
    end

    // The working bytes carry no reset; they are only meaningful in RUN and DONE.
    always_ff @(posedge clk) begin
        r_q <= r_d;
    end

    assign output_word       = out_q;
    assign finish_convertion = fin_q;
    assign state_o           = state_q;
endmodule

// File: tb/tb_l_inv_convertion.sv
// Bench for l_inv_convertion: directed vectors plus round trips through a forward-L
// model, with a queue-based scoreboard fed by the driver and drained by a monitor.

module tb_l_inv_convertion;
    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [127:0] input_word;
    logic [127:0] output_word;
    logic         finish_convertion;
    logic [1:0]   state_o;

    logic [127:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic         fin_prev = 1'b0;

    always #5 clk = ~clk;

    l_inv_convertion dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .input_word        (input_word),
        .output_word       (output_word),
        .finish_convertion (finish_convertion),
        .state_o           (state_o)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'hC3 : 8'h00);
        end
        return p;
    endfunction

    // Forward L: each round prepends l(a15..a0) and drops a0.
    function automatic logic [127:0] l_fwd(input logic [127:0] w);
        logic [7:0]   c [16];
        logic [127:0] x;
        logic [7:0]   acc;
        c = '{8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
              8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};
        x = w;
        for (int r = 0; r < 16; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 16; j++) begin
                acc = acc ^ gmul(x[8*(15-j) +: 8], c[j]);
            end
            x = {acc, x[127:8]};
        end
        return x;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising finish flag consumes one expected result.
    always @(negedge clk) begin
        if (finish_convertion && !fin_prev) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_finish: got output %h with no result pending", output_word);
            end else begin
                check("result", output_word, exp_q.pop_front());
            end
        end
        fin_prev = finish_convertion;
    end

    task automatic start_op(input logic [127:0] w, input logic [127:0] e, input bit push);
        @(negedge clk);
        enable     = 1'b1;
        input_word = w;
        if (push) exp_q.push_back(e);
    endtask

    // Counts falling edges from the one before the load edge; 18 means finish after E17.
    task automatic wait_finish(input int pre, input bit chk_lat);
        int edges;
        edges = pre;
        while (!finish_convertion && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        if (chk_lat || !finish_convertion) check("latency", 128'(edges - 1), 128'd17);
    endtask

    task automatic end_op();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("fin_drop", 128'(finish_convertion), 128'd0);
    endtask

    initial begin
        logic [127:0] x;
        logic [127:0] y;

        reset      = 1'b1;
        enable     = 1'b0;
        input_word = '0;
        repeat (3) @(negedge clk);
        check("reset_out", output_word, 128'd0);
        check("reset_fin", 128'(finish_convertion), 128'd0);
        check("reset_state", 128'(state_o), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Reference vector and all-zero block.
        start_op(128'hd456584dd0e3e84cc3166e4b7fa2890d, 128'h64a59400000000000000000000000000, 1'b1);
        wait_finish(0, 1'b1);
        end_op();
        start_op(128'd0, 128'd0, 1'b1);
        wait_finish(0, 1'b1);
        end_op();

        // Hold enable after finish: output stable, no restart.
        x = 128'h0123456789abcdeffedcba9876543210;
        start_op(l_fwd(x), x, 1'b1);
        wait_finish(0, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("hold_out", output_word, x);
            check("hold_fin", 128'(finish_convertion), 128'd1);
            check("hold_state", 128'(state_o), 128'd2);
        end
        end_op();
        y = 128'hffeeddccbbaa99887766554433221100;
        start_op(l_fwd(y), y, 1'b1);
        wait_finish(0, 1'b1);
        end_op();

        // Enable dropped around round 8 and restored before DONE: run completes.
        x = 128'h8899aabbccddeeff0011223344556677;
        start_op(l_fwd(x), x, 1'b1);
        repeat (8) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        wait_finish(12, 1'b1);
        end_op();

        // Enable low from round 8 onwards: result still loads, flag never rises.
        x = 128'h00000000000000000000000000000001;
        start_op(l_fwd(x), x, 1'b0);
        repeat (8) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        check("silent_out", output_word, x);
        check("silent_fin", 128'(finish_convertion), 128'd0);
        check("silent_state", 128'(state_o), 128'd0);

        // Reset at round 8 aborts with nothing visible.
        x = 128'hdeadbeefcafebabe0badf00d12345678;
        start_op(l_fwd(x), x, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        check("abort_out", output_word, 128'd0);
        check("abort_fin", 128'(finish_convertion), 128'd0);
        check("abort_state", 128'(state_o), 128'd0);
        repeat (20) @(negedge clk);
        check("abort_idle", 128'(state_o), 128'd0);
        y = 128'h112233445566778899aabbccddeeff00;
        start_op(l_fwd(y), y, 1'b1);
        wait_finish(0, 1'b1);
        end_op();

        // Input changes after the load edge must not leak into the result.
        x = 128'h5a5a5a5aa5a5a5a5c3c3c3c33c3c3c3c;
        start_op(l_fwd(x), x, 1'b1);
        @(negedge clk);
        input_word = rand128();
        @(negedge clk);
        input_word = 128'hffffffffffffffffffffffffffffffff;
        wait_finish(2, 1'b1);
        end_op();

        // Round trips through the forward model.
        for (int n = 0; n < 1000; n++) begin
            x = rand128();
            start_op(l_fwd(x), x, 1'b1);
            wait_finish(0, 1'b0);
            end_op();
        end

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pending_results: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end
endmodule
